hazard_detection: RTL and testbench

Stall/flush controller for the five-stage WISC pipeline; it is the counterpart of the forwarding unit. Forwarding resolves every data hazard that a bypass can cover; this block handles the ones it cannot: load-use, register-branch operand dependencies and cache-miss freezes. It sits beside ID and drives the PC, IF/ID and ID/EX write/flush controls plus a whole-pipe freeze. It also keeps a saturating stall-cycle counter for performance reporting.

---
 rtl/hazard_detection.sv | 111 +++++++++++
 tb/tb_hazard_detection.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detection.sv
// Stall/flush controller for the five-stage WISC pipeline: resolves load-use, register-branch
// and data-cache-miss hazards that forwarding cannot cover, and counts stalled cycles.
module hazard_detection (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_EX_MemRead,
    input  logic        ID_EX_RegWrite,
    input  logic [3:0]  ID_EX_RegRd,
    input  logic [3:0]  IF_ID_RegRs,
    input  logic [3:0]  IF_ID_RegRt,
    input  logic        IF_ID_UsesRt,
    input  logic        IF_ID_MemWrite,
    input  logic        ID_BR,
    input  logic        ID_branch_taken,
    input  logic        ic_miss,
    input  logic        dc_miss,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        pipe_freeze,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {StRun, StBrWait, StDmiss} state_t;

    state_t      state_q, state_d, eff_state;
    logic        br_cnt_q, br_cnt_d;
    logic [15:0] stall_q;
    logic        rd_nz, rs_match, rt_match;
    logic        load_use, br_hazard;

    assign rd_nz     = (ID_EX_RegRd != 4'd0);
    assign rs_match  = (ID_EX_RegRd == IF_ID_RegRs);
    assign rt_match  = (ID_EX_RegRd == IF_ID_RegRt);

    // Store-data Rt is left to MEM-MEM forwarding, so it never causes a load-use stall.
    assign load_use  = ID_EX_MemRead & rd_nz &
                       (rs_match | (rt_match & IF_ID_UsesRt & ~IF_ID_MemWrite));
    assign br_hazard = ID_BR & ID_EX_RegWrite & rd_nz & rs_match;

    // Leaving DMISS behaves like the state the miss interrupted, so no bubble is added.
    always_comb begin
        eff_state = state_q;
        if (state_q == StDmiss) begin
            eff_state = br_cnt_q ? StBrWait : StRun;
        end
    end

    always_comb begin
        state_d     = StRun;
        br_cnt_d    = br_cnt_q;
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        pipe_freeze = 1'b0;

        if (rst) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            br_cnt_d    = 1'b0;
        end else if (dc_miss) begin
            pipe_freeze = 1'b1;
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            state_d     = StDmiss;
        end else if (eff_state == StBrWait) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            br_cnt_d    = 1'b0;
        end else if (br_hazard) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            if (ID_EX_MemRead) begin
                br_cnt_d = 1'b1;
                state_d  = StBrWait;
            end
        end else if (load_use) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end else if (ID_branch_taken) begin
            IF_ID_flush = 1'b1;
        end else if (ic_miss) begin
            PC_write    = 1'b0;
            IF_ID_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StRun;
            br_cnt_q <= 1'b0;
            stall_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            br_cnt_q <= br_cnt_d;
            if (!PC_write && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_detection.sv
// Randomized plus directed bench for hazard_detection; a reference model pushes expected
// outputs into a queue and a negedge monitor compares them against the DUT.
module tb_hazard_detection;

    logic        clk;
    logic        rst;
    logic        ID_EX_MemRead, ID_EX_RegWrite;
    logic [3:0]  ID_EX_RegRd, IF_ID_RegRs, IF_ID_RegRt;
    logic        IF_ID_UsesRt, IF_ID_MemWrite, ID_BR, ID_branch_taken, ic_miss, dc_miss;
    logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_freeze;
    logic [15:0] stall_cycles;

    typedef struct packed {
        logic        rst;
        logic        mem_read;
        logic        reg_write;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic        uses_rt;
        logic        mem_write;
        logic        br;
        logic        taken;
        logic        ic;
        logic        dc;
    } stim_t;

    typedef struct packed {
        logic        pc_write;
        logic        if_id_write;
        logic        if_id_flush;
        logic        id_ex_flush;
        logic        freeze;
        logic [15:0] cnt;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    owed_bubbles = 0;
    int    model_cnt = 0;

    hazard_detection dut (
        .clk            (clk),
        .rst            (rst),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .ID_EX_RegWrite (ID_EX_RegWrite),
        .ID_EX_RegRd    (ID_EX_RegRd),
        .IF_ID_RegRs    (IF_ID_RegRs),
        .IF_ID_RegRt    (IF_ID_RegRt),
        .IF_ID_UsesRt   (IF_ID_UsesRt),
        .IF_ID_MemWrite (IF_ID_MemWrite),
        .ID_BR          (ID_BR),
        .ID_branch_taken(ID_branch_taken),
        .ic_miss        (ic_miss),
        .dc_miss        (dc_miss),
        .PC_write       (PC_write),
        .IF_ID_write    (IF_ID_write),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_flush    (ID_EX_flush),
        .pipe_freeze    (pipe_freeze),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Reference model: a pipeline either owes bubbles or not; misses freeze without paying them.
    task automatic apply(input stim_t s);
        resp_t e;
        bit    lu, brh, stall;
        @(posedge clk);
        #1;
        rst             = s.rst;
        ID_EX_MemRead   = s.mem_read;
        ID_EX_RegWrite  = s.reg_write;
        ID_EX_RegRd     = s.rd;
        IF_ID_RegRs     = s.rs;
        IF_ID_RegRt     = s.rt;
        IF_ID_UsesRt    = s.uses_rt;
        IF_ID_MemWrite  = s.mem_write;
        ID_BR           = s.br;
        ID_branch_taken = s.taken;
        ic_miss         = s.ic;
        dc_miss         = s.dc;

        lu  = s.mem_read && s.rd != 0 &&
              (s.rd == s.rs || (s.rd == s.rt && s.uses_rt && !s.mem_write));
        brh = s.br && s.reg_write && s.rd != 0 && s.rd == s.rs;
        e   = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0,
                freeze: 1'b0, cnt: 16'd0};
        stall = 1'b0;
        if (s.rst) begin
            e = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1, id_ex_flush: 1'b1,
                  freeze: 1'b0, cnt: 16'd0};
            owed_bubbles = 0;
            model_cnt = 0;
        end else begin
            if (s.dc) begin
                e.freeze = 1'b1;
                stall = 1'b1;
            end else if (owed_bubbles > 0) begin
                e.id_ex_flush = 1'b1;
                stall = 1'b1;
                owed_bubbles = owed_bubbles - 1;
            end else if (brh || lu) begin
                e.id_ex_flush = 1'b1;
                stall = 1'b1;
                if (brh && s.mem_read) owed_bubbles = 1;
            end else if (s.taken) begin
                e.if_id_flush = 1'b1;
            end else if (s.ic) begin
                e.pc_write = 1'b0;
                e.if_id_flush = 1'b1;
            end
            if (stall) begin
                e.pc_write = 1'b0;
                e.if_id_write = 1'b0;
            end
            e.cnt = 16'(model_cnt);
            if (!e.pc_write && model_cnt < 65535) model_cnt = model_cnt + 1;
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        resp_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{pc_write: PC_write, if_id_write: IF_ID_write, if_id_flush: IF_ID_flush,
                  id_ex_flush: ID_EX_flush, freeze: pipe_freeze, cnt: stall_cycles};
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL ctl t=%0t got pc=%b ifw=%b iff=%b idf=%b frz=%b cnt=%h want pc=%b ifw=%b iff=%b idf=%b frz=%b cnt=%h",
                         $time, a.pc_write, a.if_id_write, a.if_id_flush, a.id_ex_flush,
                         a.freeze, a.cnt, e.pc_write, e.if_id_write, e.if_id_flush,
                         e.id_ex_flush, e.freeze, e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        int    dc_run;
        rst = 1'b1;
        {ID_EX_MemRead, ID_EX_RegWrite, IF_ID_UsesRt, IF_ID_MemWrite} = '0;
        {ID_BR, ID_branch_taken, ic_miss, dc_miss} = '0;
        ID_EX_RegRd = '0;
        IF_ID_RegRs = '0;
        IF_ID_RegRt = '0;

        s = idle(); s.rst = 1'b1;
        apply(s);
        apply(s);
        apply(idle());

        // Load R3 in EX, ID reads Rs=R3.
        s = idle(); s.mem_read = 1; s.reg_write = 1; s.rd = 3; s.rs = 3;
        apply(s);
        apply(idle());
        // Store with Rt=R3 (data), Rs=R5: no stall; same store with Rs=R3: stall.
        s = idle(); s.mem_read = 1; s.reg_write = 1; s.rd = 3; s.rs = 5; s.rt = 3;
        s.uses_rt = 1; s.mem_write = 1;
        apply(s);
        s.rs = 3;
        apply(s);
        // Load to R0 never stalls.
        s = idle(); s.mem_read = 1; s.rd = 0; s.rs = 0; s.rt = 0; s.uses_rt = 1;
        apply(s);
        // BR on load result: two bubbles; on ALU result: one.
        s = idle(); s.br = 1; s.rs = 7; s.rd = 7; s.reg_write = 1; s.mem_read = 1;
        apply(s);
        apply(s);
        apply(idle());
        s.mem_read = 0;
        apply(s);
        apply(idle());
        // dc_miss held 4 cycles during BR_WAIT.
        s = idle(); s.br = 1; s.rs = 7; s.rd = 7; s.reg_write = 1; s.mem_read = 1;
        apply(s);
        s = idle(); s.dc = 1;
        repeat (4) apply(s);
        apply(idle());
        apply(idle());
        // Taken branch overrides ic_miss; ic_miss alone.
        s = idle(); s.taken = 1; s.ic = 1;
        apply(s);
        s.taken = 0;
        apply(s);

        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst       = ($urandom_range(0, 79) == 0);
            s.mem_read  = $urandom_range(0, 1);
            s.reg_write = $urandom_range(0, 1);
            s.rd        = 4'($urandom_range(0, 3));
            s.rs        = 4'($urandom_range(0, 3));
            s.rt        = 4'($urandom_range(0, 3));
            s.uses_rt   = $urandom_range(0, 1);
            s.mem_write = $urandom_range(0, 1);
            s.br        = ($urandom_range(0, 2) == 0);
            s.taken     = ($urandom_range(0, 3) == 0);
            s.ic        = ($urandom_range(0, 4) == 0);
            if (dc_run == 0 && $urandom_range(0, 11) == 0) dc_run = $urandom_range(1, 5);
            s.dc = (dc_run > 0);
            if (dc_run > 0) dc_run = dc_run - 1;
            apply(s);
        end

        // Saturate the counter under a sustained miss, then reset from BR_WAIT-interrupted DMISS.
        s = idle(); s.rst = 1;
        apply(s);
        s = idle(); s.br = 1; s.rs = 2; s.rd = 2; s.reg_write = 1; s.mem_read = 1;
        apply(s);
        s = idle(); s.dc = 1;
        repeat (65540) apply(s);
        s.rst = 1;
        apply(s);
        apply(s);
        apply(idle());
        apply(idle());

        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
